// File: rtl/bit_scan_sequencer_if.sv
// Handshake bundle for bit_scan_sequencer: mask offer on one side, index beats on the other.
interface bit_scan_sequencer_if;
   logic        inMaskValid;
   logic        inMaskReady;
   logic [31:0] inMask;
   logic        inDirection;
   logic        outValid;
   logic        outReady;
   logic [4:0]  outIndex;
   logic [5:0]  outSeq;
   logic        outLast;
   logic        outEmpty;

   modport master (
      output inMaskValid, inMask, inDirection, outReady,
      input  inMaskReady, outValid, outIndex, outSeq, outLast, outEmpty
   );

   modport slave (
      input  inMaskValid, inMask, inDirection, outReady,
      output inMaskReady, outValid, outIndex, outSeq, outLast, outEmpty
   );
endinterface

// File: rtl/bit_scan_sequencer.sv
// Enumerates the set bits of a 32-bit mask one per beat, lowest-first or highest-first.
// bitFinder is the shared find-first/find-last/popcount primitive used for the search.
module bitFinder (
   input  logic [1:0]  control,
   input  logic        flag,
   input  logic [31:0] operantA,
   input  logic [31:0] operantB,
   output logic [5:0]  result
);
   logic [31:0] effective;

   // Results are 1-based positions; 0 means no bit was found.
   always_comb begin
      effective = flag ? (operantA & operantB) : (operantA | operantB);
      result    = 6'd0;
      case (control)
         2'b01:   for (int i = 31; i >= 0; i--) if (effective[i]) result = 6'(i + 1);
         2'b11:   for (int i = 0; i < 32; i++)  if (effective[i]) result = 6'(i + 1);
         default: for (int i = 0; i < 32; i++)  result = result + {5'd0, effective[i]};
      endcase
   end
endmodule

module bit_scan_sequencer (
   input logic                 clock,
   input logic                 reset,
   input logic                 abort,
   bit_scan_sequencer_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} stateType;

   stateType    stateReg;
   logic [31:0] remainingReg;
   logic        directionReg;
   logic [5:0]  seqReg;
   logic [5:0]  findResult;
   logic [31:0] clearMask;
   logic        beatEmpty;
   logic        beatLast;
   logic        accept;
   logic        beatTaken;

   bitFinder finder (
      .control  ({directionReg, 1'b1}),
      .flag     (1'b0),
      .operantA (remainingReg),
      .operantB (32'd0),
      .result   (findResult)
   );

   assign beatEmpty = (findResult == 6'd0);
   assign beatLast  = ((remainingReg & (remainingReg - 32'd1)) == 32'd0);

   assign bus.outIndex    = beatEmpty ? 5'd0 : (findResult[4:0] - 5'd1);
   assign bus.outSeq      = seqReg;
   assign bus.outLast     = beatLast;
   assign bus.outEmpty    = beatEmpty;
   assign bus.inMaskReady = (stateReg == IDLE) & ~abort & ~reset;
   assign bus.outValid    = (stateReg == SCAN) & ~reset;

   assign accept    = bus.inMaskValid & bus.inMaskReady;
   assign beatTaken = bus.outValid & bus.outReady;

   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_clear
         assign clearMask[gi] = (findResult == 6'(gi + 1));
      end
   endgenerate

   always_ff @(posedge clock) begin
      if (reset) begin
         stateReg     <= IDLE;
         remainingReg <= 32'd0;
         seqReg       <= 6'd0;
         directionReg <= 1'b0;
      end else if (abort) begin
         stateReg     <= IDLE;
         remainingReg <= 32'd0;
         seqReg       <= 6'd0;
      end else begin
         case (stateReg)
            IDLE: begin
               if (accept) begin
                  remainingReg <= bus.inMask;
                  directionReg <= bus.inDirection;
                  seqReg       <= 6'd0;
                  stateReg     <= SCAN;
               end
            end
            SCAN: begin
               if (beatTaken) begin
                  remainingReg <= remainingReg & ~clearMask;
                  // The final beat leaves the ordinal in place so it never exceeds 31.
                  if (beatLast) stateReg <= IDLE;
                  else          seqReg   <= seqReg + 6'd1;
               end
            end
         endcase
      end
   end
endmodule
